obstacle_field: RTL and testbench
=================================

Name: obstacle_field

Overview:
Parametrised successor to the static obstacle generator. Drives NUM_OBS gate obstacles: vertical pillars with a fly-through gap, scrolling left once per frame. Respawns each obstacle off the right edge with a pseudo-random gap height, detects when the bee clears an obstacle, and keeps the pass score. Sits between the game-control FSM / bee logic and the colour mapper, and is clocked by frame_clk (one update per frame).

Parameters:
NUM_OBS, 3, number of obstacle channels (2..4)
OBS_W, 50, pillar width in pixels
GAP_H, 120, gap height in pixels
SPACING, 240, X distance between consecutive obstacles; NUM_OBS*SPACING must be in [SCREEN_W+OBS_W, 1023]
START_X, 400, initial left edge of channel 0; START_X+(NUM_OBS-1)*SPACING < 1024
GAP_MIN, 60, smallest gap top Y
GAP_SPAN, 200, gap-top range above GAP_MIN, must be in [128, 255]; GAP_MIN+GAP_SPAN+GAP_H < 480
SCREEN_W, 640, visible width
SEED, 16'hACE1, LFSR reset value (nonzero)

Ports:
frame_clk  in  1  frame clock; the only clock
Reset  in  1  synchronous, active-high reset
start  in  1  single-cycle start/restart request
hit  in  1  collision reported by the collision block
speed  in  4  pixels moved per frame; sampled every frame; 0 = stationary
BeeX  in  10  bee X position, used for pass detection
ObsX  out  NUM_OBS*10  left edge per channel; channel i at [10i+9:10i]
GapY  out  NUM_OBS*10  gap top Y per channel, same packing
ObsWidth  out  10  constant OBS_W
GapHeight  out  10  constant GAP_H
state  out  2  IDLE=0, RUN=1, FROZEN=2
pass_pulse  out  1  one-cycle pulse when the bee clears an obstacle
pass_count  out  8  obstacles passed, saturating at 255

Behaviour:
- Reset (sampled on the frame_clk edge) sets: state=IDLE; ObsX[i]=START_X+i*SPACING; GapY[i]=GAP_MIN+GAP_SPAN/2; pass_pulse=0; pass_count=0; lfsr=SEED.
- All outputs are registered. Effects of any input appear one frame_clk edge later.
- FSM transitions:
  - IDLE -> RUN on start; pass_count cleared in the same edge.
  - RUN -> FROZEN on hit. If start and hit are high together, hit wins.
  - FROZEN -> IDLE on start; positions and GapY reload to their reset values; pass_count is held until the next IDLE->RUN.
  - No other transitions; hit is ignored outside RUN.
- IDLE and FROZEN: ObsX, GapY and pass_count hold; pass_pulse=0.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Steps every edge not in reset, regardless of state.
- RUN, per channel each edge:
  - If ObsX[i] >= speed: ObsX[i] <= ObsX[i]-speed.
  - Otherwise (respawn): ObsX[i] <= ObsX[i]-speed+NUM_OBS*SPACING, computed as a 10-bit sum without intermediate underflow (add first). This preserves exact spacing.
  - Respawn also loads GapY[i] <= GAP_MIN+off, where r=lfsr[7:0] and off = r if r<=GAP_SPAN, else r-GAP_SPAN-1.
  - Multiple channels respawning on one edge all use the same off (legal only when speed >= SPACING, which is out of spec).
- Pass detection, RUN only, non-respawn channel:
  - Condition: (ObsX[i]+OBS_W >= BeeX) and (ObsX[i]-speed+OBS_W < BeeX).
  - Result: pass_pulse=1 on the next edge, pass_count +1 (saturates at 255).
  - Several channels passing on one edge still count +1.
  - Respawn edges never pulse.
  - speed=0 never pulses.
- pass_pulse is exactly one cycle wide; it is 0 on any edge with no pass.
- Reset asserted mid-RUN: the next edge forces all reset values; no pulse.
- Arithmetic is 10-bit unsigned except the pass compare, which is 11-bit to avoid overflow of ObsX+OBS_W.

Decomposition:
- Package obstacle_pkg:
  - state enum {IDLE, RUN, FROZEN}
  - coord_t = logic [9:0]
  - SCREEN_W/SCREEN_H constants
  - LFSR tap mask and width
- One sub-module: obstacle_lfsr (16-bit LFSR with synchronous Reset to SEED, free-running enable).
- The per-channel update is a generate loop in obstacle_field, not a separate module.

Test Plan:
1. Reset high 2 edges -> state=0, ObsX={880,640,400} (ch2..ch0), all GapY=160, pass_count=0, pass_pulse=0.
2. start 1 cycle, speed=2, hold 10 edges -> state=1; ch0 X=380, ch1=620, ch2=860.
3. RUN speed=2 until ch0 X=1 -> next edge ch0 X=719, GapY[0]=60+off from lfsr[7:0] per the fold rule (checked against model); other channels unaffected.
4. BeeX=100, speed=2, ch0 X 52->50->48 -> pass_pulse only on the edge after X goes 50->48, pass_count=1; pulse width 1.
5. RUN with start and hit both high -> FROZEN, positions hold 5 edges; start -> IDLE with reset positions; start -> RUN, pass_count=0.
6. Reset asserted mid-RUN at X=300 -> next edge reset values, lfsr=SEED; pass_count saturation forced to 255 stays 255 on a further pass.

Source files
------------

// File: rtl/obstacle_field_pkg.sv
// Shared types and helpers for the scrolling gate-obstacle field:
// FSM encoding, coordinate type, screen size and LFSR definition.
package obstacle_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FROZEN = 2'd2
  } state_e;

  typedef logic [9:0] coord_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam int                 LFSR_W    = 16;
  // Fibonacci taps 16,14,13,11 expressed as a mask over bits [15:0]
  localparam logic [LFSR_W-1:0]  LFSR_TAPS = 16'hB400;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
  endfunction

  // Folds a raw byte into [0, span] so every gap position stays on screen
  function automatic logic [7:0] gap_fold(input logic [7:0] r, input logic [7:0] span);
    logic [7:0] off;
    if (r <= span) begin
      off = r;
    end else begin
      off = r - span - 8'd1;
    end
    return off;
  endfunction

endpackage

// File: rtl/obstacle_field_lfsr.sv
// Free-running 16-bit Fibonacci LFSR that supplies gap-height randomness;
// only the low OUT_W bits are exported.
module obstacle_lfsr
  import obstacle_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED  = 16'hACE1,
  parameter int                OUT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [OUT_W-1:0] lfsr_o
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  // next-state: shift when enabled, otherwise hold
  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) begin
      lfsr_d = lfsr_step(lfsr_q);
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  // state register with synchronous reload of the seed
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/obstacle_field.sv
// NUM_OBS scrolling gate obstacles with random gap respawn, pass detection
// and a saturating pass score; one update per frame_clk edge.
module obstacle_field #(
  parameter int          NUM_OBS  = 3,
  parameter int          OBS_W    = 50,
  parameter int          GAP_H    = 120,
  parameter int          SPACING  = 240,
  parameter int          START_X  = 400,
  parameter int          GAP_MIN  = 60,
  parameter int          GAP_SPAN = 200,
  parameter int          SCREEN_W = 640,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic                    frame_clk,
  input  logic                    Reset,
  input  logic                    start,
  input  logic                    hit,
  input  logic [3:0]              speed,
  input  logic [9:0]              BeeX,
  output logic [NUM_OBS*10-1:0]   ObsX,
  output logic [NUM_OBS*10-1:0]   GapY,
  output logic [9:0]              ObsWidth,
  output logic [9:0]              GapHeight,
  output logic [1:0]              state,
  output logic                    pass_pulse,
  output logic [7:0]              pass_count
);
  import obstacle_pkg::*;

  localparam int     WRAP      = NUM_OBS * SPACING;
  localparam coord_t GAP_RESET = coord_t'(GAP_MIN + GAP_SPAN / 2);

  // A wrap distance shorter than the screen would pop obstacles in visibly
  if ((WRAP < SCREEN_W + OBS_W) || (WRAP > 1023)) begin : g_cfg_check
    $error("obstacle_field: NUM_OBS*SPACING outside [SCREEN_W+OBS_W, 1023]");
  end

  state_e              state_q, state_d;
  coord_t              obs_x_q [NUM_OBS];
  coord_t              obs_x_d [NUM_OBS];
  coord_t              gap_y_q [NUM_OBS];
  coord_t              gap_y_d [NUM_OBS];
  logic                pass_pulse_q, pass_pulse_d;
  logic [7:0]          pass_count_q, pass_count_d;
  logic [7:0]          lfsr_low_s;
  coord_t              respawn_gap_s;
  logic [NUM_OBS-1:0]  respawn_s;
  logic [NUM_OBS-1:0]  pass_s;
  logic [NUM_OBS*10-1:0] move_x_s;

  function automatic coord_t home_x(input int idx);
    return coord_t'(START_X + idx * SPACING);
  endfunction

  obstacle_lfsr #(
    .SEED  (SEED),
    .OUT_W (8)
  ) u_lfsr (
    .clk_i  (frame_clk),
    .rst_i  (Reset),
    .en_i   (1'b1),
    .lfsr_o (lfsr_low_s)
  );

  assign respawn_gap_s = coord_t'(GAP_MIN) + {2'b00, gap_fold(lfsr_low_s, 8'(GAP_SPAN))};

  for (genvar g = 0; g < NUM_OBS; g++) begin : g_ch
    logic [10:0] lead_s;
    logic [10:0] trail_s;
    logic [10:0] bee_s;

    // 11-bit compare so ObsX+OBS_W cannot wrap; respawn is added before subtracting
    assign bee_s        = {1'b0, BeeX};
    assign respawn_s[g] = obs_x_q[g] < {6'd0, speed};
    assign lead_s       = {1'b0, obs_x_q[g]} + 11'(OBS_W);
    assign trail_s      = {1'b0, obs_x_q[g]} - {7'd0, speed} + 11'(OBS_W);
    assign pass_s[g]    = ~respawn_s[g] & (lead_s >= bee_s) & (trail_s < bee_s);
    assign move_x_s[g*10 +: 10] = respawn_s[g]
                                ? (obs_x_q[g] + coord_t'(WRAP) - {6'd0, speed})
                                : (obs_x_q[g] - {6'd0, speed});

    assign ObsX[g*10 +: 10] = obs_x_q[g];
    assign GapY[g*10 +: 10] = gap_y_q[g];
  end

  assign ObsWidth   = 10'(OBS_W);
  assign GapHeight  = 10'(GAP_H);
  assign state      = state_q;
  assign pass_pulse = pass_pulse_q;
  assign pass_count = pass_count_q;

  // game FSM next-state plus per-channel scroll, respawn and scoring
  always_comb begin
    state_d      = state_q;
    obs_x_d      = obs_x_q;
    gap_y_d      = gap_y_q;
    pass_pulse_d = 1'b0;
    pass_count_d = pass_count_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = RUN;
          pass_count_d = 8'd0;
        end else begin
          state_d      = IDLE;
        end
      end
      RUN: begin
        for (int i = 0; i < NUM_OBS; i++) begin
          obs_x_d[i] = move_x_s[i*10 +: 10];
          if (respawn_s[i]) begin
            gap_y_d[i] = respawn_gap_s;
          end else begin
            gap_y_d[i] = gap_y_q[i];
          end
        end
        // simultaneous passes on one edge score a single point
        if (|pass_s) begin
          pass_pulse_d = 1'b1;
          if (pass_count_q != 8'd255) begin
            pass_count_d = pass_count_q + 8'd1;
          end else begin
            pass_count_d = pass_count_q;
          end
        end else begin
          pass_pulse_d = 1'b0;
        end
        if (hit) begin
          state_d = FROZEN;
        end else begin
          state_d = RUN;
        end
      end
      FROZEN: begin
        if (start) begin
          state_d = IDLE;
          for (int i = 0; i < NUM_OBS; i++) begin
            obs_x_d[i] = home_x(i);
            gap_y_d[i] = GAP_RESET;
          end
        end else begin
          state_d = FROZEN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // frame registers with synchronous reset to the starting layout
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q      <= IDLE;
      pass_pulse_q <= 1'b0;
      pass_count_q <= 8'd0;
      for (int i = 0; i < NUM_OBS; i++) begin
        obs_x_q[i] <= home_x(i);
        gap_y_q[i] <= GAP_RESET;
      end
    end else begin
      state_q      <= state_d;
      pass_pulse_q <= pass_pulse_d;
      pass_count_q <= pass_count_d;
      for (int i = 0; i < NUM_OBS; i++) begin
        obs_x_q[i] <= obs_x_d[i];
        gap_y_q[i] <= gap_y_d[i];
      end
    end
  end

endmodule

// File: tb/tb_obstacle_field.sv
// Directed self-checking bench for obstacle_field with default parameters
// (three channels at 400/640/880, wrap distance 720).
module tb_obstacle_field;

  logic        frame_clk = 1'b0;
  logic        Reset     = 1'b1;
  logic        start     = 1'b0;
  logic        hit       = 1'b0;
  logic [3:0]  speed     = 4'd0;
  logic [9:0]  BeeX      = 10'd1023;
  logic [29:0] ObsX;
  logic [29:0] GapY;
  logic [9:0]  ObsWidth;
  logic [9:0]  GapHeight;
  logic [1:0]  state;
  logic        pass_pulse;
  logic [7:0]  pass_count;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] lfsr_m = 16'hACE1;
  logic [7:0]  last_r = 8'd0;

  localparam logic [29:0] X_HOME   = {10'd880, 10'd640, 10'd400};
  localparam logic [29:0] GAP_HOME = {10'd160, 10'd160, 10'd160};

  obstacle_field dut (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .start      (start),
    .hit        (hit),
    .speed      (speed),
    .BeeX       (BeeX),
    .ObsX       (ObsX),
    .GapY       (GapY),
    .ObsWidth   (ObsWidth),
    .GapHeight  (GapHeight),
    .state      (state),
    .pass_pulse (pass_pulse),
    .pass_count (pass_count)
  );

  always #5 frame_clk = ~frame_clk;

  function automatic logic [9:0] ox(input int i);
    return ObsX[i*10 +: 10];
  endfunction

  function automatic logic [9:0] exp_gap(input logic [7:0] r);
    logic [7:0] off;
    if (r <= 8'd200) off = r;
    else             off = r - 8'd201;
    return 10'd60 + {2'b00, off};
  endfunction

  // one frame edge; tracks the LFSR value the DUT used on that edge
  task automatic tick();
    logic [15:0] pre;
    pre = lfsr_m;
    @(posedge frame_clk);
    #1;
    last_r = pre[7:0];
    if (Reset) lfsr_m = 16'hACE1;
    else       lfsr_m = {pre[14:0], pre[15] ^ pre[13] ^ pre[12] ^ pre[10]};
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
    checks++; if (ObsX !== X_HOME) begin errors++; $display("FAIL reset_obsx got %h want %h", ObsX, X_HOME); end
    checks++; if (GapY !== GAP_HOME) begin errors++; $display("FAIL reset_gapy got %h want %h", GapY, GAP_HOME); end
    checks++; if (pass_count !== 8'd0) begin errors++; $display("FAIL reset_count got %0d want 0", pass_count); end
    checks++; if (pass_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse got %b want 0", pass_pulse); end
    checks++; if (ObsWidth !== 10'd50 || GapHeight !== 10'd120) begin errors++; $display("FAIL const_dims got %0d/%0d want 50/120", ObsWidth, GapHeight); end
  endtask

  task automatic test_start_scroll();
    BeeX  = 10'd1023;
    speed = 4'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL start_state got %0d want 1", state); end
    checks++; if (ObsX !== X_HOME) begin errors++; $display("FAIL start_edge_x got %h want %h", ObsX, X_HOME); end
    repeat (10) tick();
    checks++; if (ObsX !== {10'd860, 10'd620, 10'd380}) begin errors++; $display("FAIL scroll_10 got %0d/%0d/%0d want 860/620/380", ox(2), ox(1), ox(0)); end
  endtask

  task automatic test_respawn();
    int n;
    logic [9:0] g;
    n = 0;
    while (ox(0) != 10'd2 && n < 400) begin tick(); n++; end
    checks++; if (ox(0) !== 10'd2) begin errors++; $display("FAIL approach_2 got %0d want 2", ox(0)); end
    speed = 4'd1;
    tick();
    checks++; if (ObsX !== {10'd481, 10'd241, 10'd1}) begin errors++; $display("FAIL at_x1 got %0d/%0d/%0d want 481/241/1", ox(2), ox(1), ox(0)); end
    speed = 4'd2;
    tick();
    g = exp_gap(last_r);
    checks++; if (ObsX !== {10'd479, 10'd239, 10'd719}) begin errors++; $display("FAIL respawn_x got %0d/%0d/%0d want 479/239/719", ox(2), ox(1), ox(0)); end
    checks++; if (GapY !== {10'd160, 10'd160, g}) begin errors++; $display("FAIL respawn_gap got %h want %h", GapY, {10'd160, 10'd160, g}); end
    checks++; if (pass_pulse !== 1'b0 || pass_count !== 8'd0) begin errors++; $display("FAIL respawn_nopass got %b/%0d want 0/0", pass_pulse, pass_count); end
  endtask

  task automatic test_pass();
    int n;
    n = 0;
    while (ox(0) != 10'd55 && n < 400) begin tick(); n++; end
    checks++; if (ox(0) !== 10'd55) begin errors++; $display("FAIL approach_55 got %0d want 55", ox(0)); end
    speed = 4'd1;
    tick();
    checks++; if (ObsX !== {10'd534, 10'd294, 10'd54}) begin errors++; $display("FAIL at_x54 got %0d/%0d/%0d want 534/294/54", ox(2), ox(1), ox(0)); end
    checks++; if (pass_count !== 8'd0) begin errors++; $display("FAIL far_bee_count got %0d want 0", pass_count); end
    BeeX  = 10'd100;
    speed = 4'd2;
    tick();
    checks++; if (ox(0) !== 10'd52 || pass_pulse !== 1'b0) begin errors++; $display("FAIL x52 got %0d/%b want 52/0", ox(0), pass_pulse); end
    tick();
    checks++; if (ox(0) !== 10'd50 || pass_pulse !== 1'b0 || pass_count !== 8'd0) begin errors++; $display("FAIL x50 got %0d/%b/%0d want 50/0/0", ox(0), pass_pulse, pass_count); end
    tick();
    checks++; if (ox(0) !== 10'd48 || pass_pulse !== 1'b1 || pass_count !== 8'd1) begin errors++; $display("FAIL x48_pass got %0d/%b/%0d want 48/1/1", ox(0), pass_pulse, pass_count); end
    tick();
    checks++; if (ox(0) !== 10'd46 || pass_pulse !== 1'b0 || pass_count !== 8'd1) begin errors++; $display("FAIL pulse_width got %0d/%b/%0d want 46/0/1", ox(0), pass_pulse, pass_count); end
    speed = 4'd0;
    BeeX  = 10'd96;
    tick();
    checks++; if (ObsX !== {10'd526, 10'd286, 10'd46} || pass_pulse !== 1'b0) begin errors++; $display("FAIL speed0 got %h/%b want hold/0", ObsX, pass_pulse); end
  endtask

  task automatic test_freeze();
    speed = 4'd0;
    start = 1'b1;
    hit   = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL hit_wins got %0d want 2", state); end
    speed = 4'd2;
    repeat (5) tick();
    checks++; if (state !== 2'd2 || ObsX !== {10'd526, 10'd286, 10'd46}) begin errors++; $display("FAIL frozen_hold got %0d/%h want 2/hold", state, ObsX); end
    checks++; if (pass_pulse !== 1'b0 || pass_count !== 8'd1) begin errors++; $display("FAIL frozen_score got %b/%0d want 0/1", pass_pulse, pass_count); end
    hit   = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (state !== 2'd0 || ObsX !== X_HOME || GapY !== GAP_HOME) begin errors++; $display("FAIL to_idle got %0d/%h/%h want 0/home", state, ObsX, GapY); end
    checks++; if (pass_count !== 8'd1) begin errors++; $display("FAIL idle_count_held got %0d want 1", pass_count); end
    tick();
    checks++; if (state !== 2'd0 || ObsX !== X_HOME) begin errors++; $display("FAIL idle_hold got %0d/%h want 0/home", state, ObsX); end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (state !== 2'd1 || pass_count !== 8'd0) begin errors++; $display("FAIL restart got %0d/%0d want 1/0", state, pass_count); end
  endtask

  task automatic test_reset_mid_run();
    BeeX  = 10'd1023;
    speed = 4'd2;
    repeat (50) tick();
    checks++; if (ox(0) !== 10'd300 || state !== 2'd1) begin errors++; $display("FAIL run_x300 got %0d/%0d want 300/1", ox(0), state); end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    checks++; if (state !== 2'd0 || ObsX !== X_HOME || GapY !== GAP_HOME) begin errors++; $display("FAIL midrun_reset got %0d/%h/%h want 0/home", state, ObsX, GapY); end
    checks++; if (pass_count !== 8'd0 || pass_pulse !== 1'b0) begin errors++; $display("FAIL midrun_score got %0d/%b want 0/0", pass_count, pass_pulse); end
    checks++; if (dut.u_lfsr.lfsr_q !== 16'hACE1) begin errors++; $display("FAIL lfsr_seed got %h want ace1", dut.u_lfsr.lfsr_q); end
  endtask

  task automatic test_saturation();
    int n;
    int pulses;
    start = 1'b1;
    speed = 4'd15;
    BeeX  = 10'd100;
    tick();
    start = 1'b0;
    pulses = 0;
    n = 0;
    while (pass_count != 8'd255 && n < 6000) begin
      tick();
      n++;
      if (pass_pulse) pulses++;
    end
    checks++; if (pass_count !== 8'd255) begin errors++; $display("FAIL reach_255 got %0d want 255", pass_count); end
    checks++; if (pulses != 255) begin errors++; $display("FAIL pulses_to_255 got %0d want 255", pulses); end
    pulses = 0;
    repeat (100) begin
      tick();
      if (pass_pulse) pulses++;
    end
    checks++; if (pass_count !== 8'd255) begin errors++; $display("FAIL saturate got %0d want 255", pass_count); end
    checks++; if (pulses < 6) begin errors++; $display("FAIL pulses_after_sat got %0d want >=6", pulses); end
  endtask

  initial begin
    test_reset();
    test_start_scroll();
    test_respawn();
    test_pass();
    test_freeze();
    test_reset_mid_run();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
